// File: rtl/counter_pkg.sv
// Shared definitions for the pulse-driven counter: mode constants and the
// event encoding produced by the priority decoder.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_INC,
        EV_DEC,
        EV_LOAD,
        EV_CANCEL
    } event_e;

    // Load dominates; simultaneous inc/dec annihilate each other.
    function automatic event_e decode_event(input logic inc, input logic dec, input logic load);
        event_e ev;
        ev = EV_NONE;
        if (load) begin
            ev = EV_LOAD;
        end else if (inc && dec) begin
            ev = EV_CANCEL;
        end else if (inc) begin
            ev = EV_INC;
        end else if (dec) begin
            ev = EV_DEC;
        end
        return ev;
    endfunction

endpackage

// File: rtl/counter_n_pulse_route_pulse_capture.sv
// Toggle/ack event capture: an input pulse flips req, the GCLK edge copies it
// into ack, so an event is pending while the two differ.
module pulse_capture (
    input  logic gclk_i,
    input  logic rst_i,
    input  logic pulse_i,
    output logic pending_c_o
);

    logic req_q;
    logic req_d;
    logic ack_q;

    assign req_d = ~req_q;

    always_ff @(posedge pulse_i or posedge rst_i) begin
        if (rst_i) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    always_ff @(posedge gclk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= req_q;
        end
    end

    assign pending_c_o = req_q ^ ack_q;

endmodule

// File: rtl/counter_n_pulse_route.sv
// Up/down/load counter for the pulse fabric: events are captured between GCLK
// pulses and applied on the next GCLK rising edge.
module counter_n_pulse_route
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic             GCLK_Pad,
    input  logic             rst_Pad,
    input  logic             inc_Pad,
    input  logic             dec_Pad,
    input  logic             load_Pad,
    input  logic [WIDTH-1:0] din_Pad,
    output logic [WIDTH-1:0] count_Pad,
    output logic             tc_Pad
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    logic             inc_pend;
    logic             dec_pend;
    logic             load_pend;
    event_e           ev;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    pulse_capture u_cap_inc (
        .gclk_i      (GCLK_Pad),
        .rst_i       (rst_Pad),
        .pulse_i     (inc_Pad),
        .pending_c_o (inc_pend)
    );

    pulse_capture u_cap_dec (
        .gclk_i      (GCLK_Pad),
        .rst_i       (rst_Pad),
        .pulse_i     (dec_Pad),
        .pending_c_o (dec_pend)
    );

    pulse_capture u_cap_load (
        .gclk_i      (GCLK_Pad),
        .rst_i       (rst_Pad),
        .pulse_i     (load_Pad),
        .pending_c_o (load_pend)
    );

    // Out-of-range load values are clamped before they reach the shadow.
    assign shadow_d = (32'(din_Pad) >= MODULUS) ? CNT_MAX : din_Pad;

    always_ff @(posedge load_Pad or posedge rst_Pad) begin
        if (rst_Pad) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign ev = decode_event(inc_pend, dec_pend, load_pend);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        case (ev)
            EV_LOAD: count_d = shadow_q;
            EV_INC: begin
                if (count_q == CNT_MAX) begin
                    tc_d = 1'b1;
                    if (SATURATE == CNT_WRAP) begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            EV_DEC: begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (SATURATE == CNT_WRAP) begin
                        count_d = CNT_MAX;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge GCLK_Pad or posedge rst_Pad) begin
        if (rst_Pad) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_Pad = count_q;
    assign tc_Pad    = tc_q;

endmodule

// File: tb/tb_counter_n_pulse_route.sv
// Scoreboard bench: one wrapping (MOD 16) and one saturating (MOD 10) counter
// driven by the same pulse stimulus, each checked against its own model.
`timescale 1ps/1ps
module tb_counter_n_pulse_route;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inc_p = 1'b0;
    logic       dec_p = 1'b0;
    logic       load_p = 1'b0;
    logic [3:0] din = 4'd0;
    logic [3:0] cnt_w;
    logic       tc_w;
    logic [3:0] cnt_s;
    logic       tc_s;

    int n_cmp = 0;
    int n_err = 0;

    exp_t       sb_w[$];
    exp_t       sb_s[$];
    exp_t       mw;
    exp_t       ms;
    logic [3:0] msh;

    always #500 clk = ~clk;

    counter_n_pulse_route #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_dut_wrap (
        .GCLK_Pad  (clk),
        .rst_Pad   (rst),
        .inc_Pad   (inc_p),
        .dec_Pad   (dec_p),
        .load_Pad  (load_p),
        .din_Pad   (din),
        .count_Pad (cnt_w),
        .tc_Pad    (tc_w)
    );

    counter_n_pulse_route #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_dut_sat (
        .GCLK_Pad  (clk),
        .rst_Pad   (rst),
        .inc_Pad   (inc_p),
        .dec_Pad   (dec_p),
        .load_Pad  (load_p),
        .din_Pad   (din),
        .count_Pad (cnt_s),
        .tc_Pad    (tc_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t step(input int unsigned m, input bit sat, input exp_t cur,
                                  input bit i, input bit d, input bit l, input logic [3:0] sh);
        exp_t r;
        r.cnt = cur.cnt;
        r.tc  = 1'b0;
        if (l) begin
            r.cnt = (int'(sh) >= int'(m)) ? 4'(m - 1) : sh;
        end else if (i && d) begin
            r.cnt = cur.cnt;
        end else if (i) begin
            if (int'(cur.cnt) == int'(m - 1)) begin
                r.tc  = 1'b1;
                r.cnt = sat ? cur.cnt : 4'd0;
            end else begin
                r.cnt = cur.cnt + 4'd1;
            end
        end else if (d) begin
            if (cur.cnt == 4'd0) begin
                r.tc  = 1'b1;
                r.cnt = sat ? cur.cnt : 4'(m - 1);
            end else begin
                r.cnt = cur.cnt - 4'd1;
            end
        end
        return r;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_w.size() == 0 || sb_s.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty got %0d entries expected 1", tag, sb_w.size());
        end else begin
            e = sb_w.pop_front();
            check({tag, "/wrap_cnt"}, 32'(cnt_w), 32'(e.cnt));
            check({tag, "/wrap_tc"}, 32'(tc_w), 32'(e.tc));
            e = sb_s.pop_front();
            check({tag, "/sat_cnt"}, 32'(cnt_s), 32'(e.cnt));
            check({tag, "/sat_tc"}, 32'(tc_s), 32'(e.tc));
        end
    endtask

    // One GCLK period: up to two pulses per input late in the period, then compare.
    task automatic run_cycle(input string tag, input int n_inc, input int n_dec,
                             input int n_load, input logic [3:0] dval);
        bit i_ev;
        bit d_ev;
        bit l_ev;
        @(negedge clk);
        din = dval;
        #420;
        for (int k = 0; k < 2; k++) begin
            if (k < n_inc)  inc_p  = 1'b1;
            if (k < n_dec)  dec_p  = 1'b1;
            if (k < n_load) load_p = 1'b1;
            #10;
            inc_p  = 1'b0;
            dec_p  = 1'b0;
            load_p = 1'b0;
            #10;
        end
        i_ev = (n_inc % 2) == 1;
        d_ev = (n_dec % 2) == 1;
        l_ev = (n_load % 2) == 1;
        if (n_load > 0) msh = dval;
        mw = step(16, 1'b0, mw, i_ev, d_ev, l_ev, msh);
        ms = step(10, 1'b1, ms, i_ev, d_ev, l_ev, msh);
        sb_w.push_back(mw);
        sb_s.push_back(ms);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        mw  = '0;
        ms  = '0;
        msh = 4'd0;
        #5;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset/wrap_cnt", 32'(cnt_w), 32'd0);
        check("reset/wrap_tc", 32'(tc_w), 32'd0);
        check("reset/sat_cnt", 32'(cnt_s), 32'd0);
        check("reset/sat_tc", 32'(tc_s), 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 17; n++) run_cycle("t1_inc", 1, 0, 0, 4'd0);

        run_cycle("t2_load12", 0, 0, 1, 4'd12);
        run_cycle("t2_inc", 1, 0, 0, 4'd0);
        run_cycle("t2_inc", 1, 0, 0, 4'd0);
        run_cycle("t2_dec", 0, 1, 0, 4'd0);

        run_cycle("t3_load5", 0, 0, 1, 4'd5);
        run_cycle("t3_incdec", 1, 1, 0, 4'd0);
        run_cycle("t3_inc", 1, 0, 0, 4'd0);

        run_cycle("t4_load3", 0, 0, 1, 4'd3);
        run_cycle("t4_load7inc", 1, 0, 1, 4'd7);
        run_cycle("t4_inc2x", 2, 0, 0, 4'd0);

        run_cycle("t5_load0", 0, 0, 1, 4'd0);
        run_cycle("t5_dec", 0, 1, 0, 4'd0);

        // Reset mid-period with an increment already captured.
        @(negedge clk);
        #100;
        inc_p = 1'b1;
        #10;
        inc_p = 1'b0;
        #20;
        rst = 1'b1;
        #5;
        check("t5_rst/wrap_cnt", 32'(cnt_w), 32'd0);
        check("t5_rst/wrap_tc", 32'(tc_w), 32'd0);
        check("t5_rst/sat_cnt", 32'(cnt_s), 32'd0);
        check("t5_rst/sat_tc", 32'(tc_s), 32'd0);
        #20;
        rst = 1'b0;
        mw  = '0;
        ms  = '0;
        msh = 4'd0;
        sb_w.push_back(mw);
        sb_s.push_back(ms);
        @(posedge clk);
        #1;
        compare_out("t5_post_rst");

        for (int n = 0; n < 20; n++) run_cycle("t6_idle", 0, 0, 0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
